// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches over a req/ack handshake,
// issues {opcode, literal} to the decoder and resolves the next PC.
module fetch_unit #(
  parameter int unsigned PC_W  = 8,
  parameter int unsigned OPC_W = 7,
  parameter int unsigned LIT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   imem_req,
  output logic [PC_W-1:0]        imem_addr,
  input  logic                   imem_ack,
  input  logic [OPC_W+LIT_W-1:0] imem_rdata,
  output logic [OPC_W-1:0]       opcode,
  output logic [LIT_W-1:0]       lit,
  output logic                   instr_valid,
  input  logic                   exec_ready,
  input  logic                   pc_load,
  input  logic [2:0]             jmp_cond,
  input  logic                   Z,
  input  logic                   N,
  input  logic                   C,
  input  logic                   halt,
  output logic [PC_W-1:0]        pc,
  output logic                   halted
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_ISSUE = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [PC_W-1:0]    r_pc;
  logic [OPC_W-1:0]   r_opcode;
  logic [LIT_W-1:0]   r_lit;
  logic               r_halt_lat;
  logic               w_capture;
  logic               w_retire;
  logic               w_cond_true;
  logic               w_halt_pend;

  // A halt arriving in the retiring cycle itself still stops fetch.
  assign w_halt_pend = r_halt_lat | halt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_FETCH;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    w_capture   = 1'b0;
    w_retire    = 1'b0;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    halted      = 1'b0;
    case (r_state)
      S_FETCH, S_WAIT: begin
        imem_req = ~rst;
        if (imem_ack) begin
          w_capture = 1'b1;
          w_next    = S_ISSUE;
        end else begin
          w_next    = S_WAIT;
        end
      end
      S_ISSUE: begin
        instr_valid = 1'b1;
        if (exec_ready) begin
          w_retire = 1'b1;
          w_next   = w_halt_pend ? S_HALT : S_FETCH;
        end
      end
      S_HALT: begin
        halted = 1'b1;
        w_next = S_HALT;
      end
      default: w_next = S_FETCH;
    endcase
  end

  always_comb begin
    w_cond_true = 1'b0;
    case (jmp_cond)
      3'b000:  w_cond_true = 1'b1;
      3'b001:  w_cond_true = Z;
      3'b010:  w_cond_true = ~Z;
      3'b011:  w_cond_true = ~N & ~Z;
      3'b100:  w_cond_true = N;
      3'b101:  w_cond_true = ~N;
      3'b110:  w_cond_true = N | Z;
      3'b111:  w_cond_true = C;
      default: w_cond_true = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc       <= '0;
      r_opcode   <= '0;
      r_lit      <= '0;
      r_halt_lat <= 1'b0;
    end else begin
      if (halt) r_halt_lat <= 1'b1;
      if (w_capture) begin
        r_opcode <= imem_rdata[OPC_W+LIT_W-1:LIT_W];
        r_lit    <= imem_rdata[LIT_W-1:0];
      end
      // Literal doubles as the absolute jump target.
      if (w_retire) begin
        if (pc_load && w_cond_true) r_pc <= PC_W'(r_lit);
        else                        r_pc <= r_pc + PC_W'(1);
      end
    end
  end

  assign imem_addr = r_pc;
  assign pc        = r_pc;
  assign opcode    = r_opcode;
  assign lit       = r_lit;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: behavioural ROM with programmable ack delay,
// table-driven jump-condition vectors and hand-written multi-cycle sequences.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack;
  logic [14:0] imem_rdata;
  logic [6:0]  opcode;
  logic [7:0]  lit;
  logic        instr_valid;
  logic        exec_ready;
  logic        pc_load;
  logic [2:0]  jmp_cond;
  logic        fz, fn, fc;
  logic        halt;
  logic [7:0]  pc;
  logic        halted;

  int n_checks = 0;
  int n_errors = 0;

  logic [14:0] rom [256];
  int          mem_delay;
  int          mem_cnt;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata),
    .opcode(opcode), .lit(lit), .instr_valid(instr_valid),
    .exec_ready(exec_ready), .pc_load(pc_load), .jmp_cond(jmp_cond),
    .Z(fz), .N(fn), .C(fc), .halt(halt),
    .pc(pc), .halted(halted)
  );

  // ROM answers after mem_delay wait cycles of a continuous request.
  assign imem_ack   = imem_req && (mem_cnt == mem_delay);
  assign imem_rdata = rom[imem_addr];

  always @(posedge clk or posedge rst) begin
    if (rst)                       mem_cnt <= 0;
    else if (!imem_req || imem_ack) mem_cnt <= 0;
    else                           mem_cnt <= mem_cnt + 1;
  end

  typedef struct {
    logic       ld;
    logic [2:0] cond;
    logic       z;
    logic       n;
    logic       c;
    logic [7:0] exp_pc;
  } vec_t;

  vec_t vecs [13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 15'(i * 3);
    rom[0] = 15'h1234;
    rom[1] = 15'h0205;

    vecs[0]  = '{1'b1, 3'b001, 1'b1, 1'b0, 1'b0, 8'h40};
    vecs[1]  = '{1'b1, 3'b001, 1'b0, 1'b0, 1'b0, 8'h01};
    vecs[2]  = '{1'b1, 3'b011, 1'b0, 1'b1, 1'b0, 8'h01};
    vecs[3]  = '{1'b1, 3'b111, 1'b0, 1'b0, 1'b1, 8'h40};
    vecs[4]  = '{1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 8'h01};
    vecs[5]  = '{1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 8'h40};
    vecs[6]  = '{1'b1, 3'b010, 1'b0, 1'b0, 1'b0, 8'h40};
    vecs[7]  = '{1'b1, 3'b011, 1'b0, 1'b0, 1'b0, 8'h40};
    vecs[8]  = '{1'b1, 3'b100, 1'b0, 1'b1, 1'b0, 8'h40};
    vecs[9]  = '{1'b1, 3'b101, 1'b0, 1'b1, 1'b0, 8'h01};
    vecs[10] = '{1'b1, 3'b110, 1'b1, 1'b0, 1'b0, 8'h40};
    vecs[11] = '{1'b1, 3'b111, 1'b0, 1'b0, 1'b0, 8'h01};
    vecs[12] = '{1'b1, 3'b110, 1'b0, 1'b0, 1'b0, 8'h01};

    rst = 1'b1; exec_ready = 1'b1; pc_load = 1'b0; jmp_cond = 3'b000;
    fz = 1'b0; fn = 1'b0; fc = 1'b0; halt = 1'b0; mem_delay = 0;

    // Reset values
    @(posedge clk); #1;
    chk("rst_pc", 32'(pc), 32'h0);
    chk("rst_req", 32'(imem_req), 32'h0);
    chk("rst_addr", 32'(imem_addr), 32'h0);
    chk("rst_opcode", 32'(opcode), 32'h0);
    chk("rst_lit", 32'(lit), 32'h0);
    chk("rst_valid", 32'(instr_valid), 32'h0);
    chk("rst_halted", 32'(halted), 32'h0);
    rst = 1'b0; #1;
    chk("req_after_rst", 32'(imem_req), 32'h1);

    // Zero-wait sequential fetch
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("zw_valid%0d", k), 32'(instr_valid), 32'(k % 2));
      if (k % 2 == 0) begin
        chk($sformatf("zw_req%0d", k), 32'(imem_req), 32'h1);
        chk($sformatf("zw_addr%0d", k), 32'(imem_addr), 32'(k / 2));
      end
      if (k == 3) begin
        chk("zw_opcode1", 32'(opcode), 32'h02);
        chk("zw_lit1", 32'(lit), 32'h05);
      end
      tick();
    end

    // Three-cycle ack delay: 4 request cycles then issue, period 5
    mem_delay = 3;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("wd_req%0d", k), 32'(imem_req), 32'h1);
      chk($sformatf("wd_addr%0d", k), 32'(imem_addr), 32'h0);
      chk($sformatf("wd_valid%0d", k), 32'(instr_valid), 32'h0);
      tick();
    end
    chk("wd_issue", 32'(instr_valid), 32'h1);
    chk("wd_issue_req", 32'(imem_req), 32'h0);
    tick();
    chk("wd_next_req", 32'(imem_req), 32'h1);
    chk("wd_next_addr", 32'(imem_addr), 32'h1);

    // exec_ready stalls for 2 cycles
    mem_delay = 0;
    exec_ready = 1'b0;
    do_reset();
    tick();
    for (int k = 0; k < 3; k++) begin
      if (k == 2) exec_ready = 1'b1;
      chk($sformatf("st_valid%0d", k), 32'(instr_valid), 32'h1);
      chk($sformatf("st_opcode%0d", k), 32'(opcode), 32'h12);
      chk($sformatf("st_pc%0d", k), 32'(pc), 32'h0);
      tick();
    end
    chk("st_valid_end", 32'(instr_valid), 32'h0);
    chk("st_pc_end", 32'(pc), 32'h1);

    // Jump-condition table
    rom[0] = {7'h05, 8'h40};
    for (int i = 0; i < 13; i++) begin
      pc_load = vecs[i].ld; jmp_cond = vecs[i].cond;
      fz = vecs[i].z; fn = vecs[i].n; fc = vecs[i].c;
      do_reset();
      tick();
      chk($sformatf("jmp%0d_valid", i), 32'(instr_valid), 32'h1);
      tick();
      chk($sformatf("jmp%0d_pc", i), 32'(pc), 32'(vecs[i].exp_pc));
    end
    fz = 1'b0; fn = 1'b0; fc = 1'b0;

    // Taken jump and halt in the same retiring cycle
    pc_load = 1'b1; jmp_cond = 3'b000;
    do_reset();
    tick();
    halt = 1'b1;
    tick();
    halt = 1'b0;
    chk("hj_pc", 32'(pc), 32'h40);
    chk("hj_halted", 32'(halted), 32'h1);

    // PC wrap, then halt pulsed during WAIT
    rom[0] = {7'h03, 8'hFF};
    do_reset();
    tick(); tick();
    chk("wrap_pre", 32'(pc), 32'hFF);
    pc_load = 1'b0;
    tick(); tick();
    chk("wrap_pc", 32'(pc), 32'h00);
    mem_delay = 2;
    tick();
    halt = 1'b1;
    tick();
    halt = 1'b0;
    chk("hw_req_wait", 32'(imem_req), 32'h1);
    chk("hw_halted_early", 32'(halted), 32'h0);
    tick();
    chk("hw_issue", 32'(instr_valid), 32'h1);
    tick();
    chk("hw_pc", 32'(pc), 32'h01);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("hw_halted%0d", k), 32'(halted), 32'h1);
      chk($sformatf("hw_req%0d", k), 32'(imem_req), 32'h0);
      chk($sformatf("hw_valid%0d", k), 32'(instr_valid), 32'h0);
      chk($sformatf("hw_pcfrz%0d", k), 32'(pc), 32'h01);
      tick();
    end

    // Reset in the middle of a WAIT at pc=0x12
    rom[0] = {7'h00, 8'h12};
    pc_load = 1'b1; mem_delay = 0;
    do_reset();
    tick(); tick();
    pc_load = 1'b0;
    mem_delay = 5;
    tick(); tick();
    chk("mr_addr_pre", 32'(imem_addr), 32'h12);
    chk("mr_req_pre", 32'(imem_req), 32'h1);
    rst = 1'b1; #1;
    chk("mr_pc", 32'(pc), 32'h0);
    chk("mr_req", 32'(imem_req), 32'h0);
    chk("mr_addr", 32'(imem_addr), 32'h0);
    chk("mr_opcode", 32'(opcode), 32'h0);
    chk("mr_lit", 32'(lit), 32'h0);
    chk("mr_valid", 32'(instr_valid), 32'h0);
    chk("mr_halted", 32'(halted), 32'h0);
    mem_delay = 0;
    tick();
    rst = 1'b0; #1;
    chk("mr_restart_req", 32'(imem_req), 32'h1);
    chk("mr_restart_addr", 32'(imem_addr), 32'h0);
    tick();
    chk("mr_restart_lit", 32'(lit), 32'h12);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
